// File: rtl/stereo_pkg.sv
// Shared definitions for the stereo disparity front end.
// Holds the packer FSM state encoding, default image geometry and the
// packed BRAM word type (lane 0 in the least significant byte).
package stereo_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } packer_state_t;

  localparam int PIX_W         = 8;
  localparam int BLOCK_SIZE    = 6;
  localparam int IMG_COLS      = 240;
  localparam int IMG_ROWS      = 320;
  localparam int WORDS_PER_ROW = IMG_COLS / BLOCK_SIZE;

  typedef logic [BLOCK_SIZE-1:0][PIX_W-1:0] packed_word_t;

endpackage

// File: rtl/stereo_frame_packer_if.sv
// Pixel-stream and BRAM write-port bundle for one eye's frame packer.
//   pixel_valid_in / pixel_in / sof_in : raster pixel stream into the packer
//   bram_we_out / bram_addr_out / bram_din_out : word write port to image BRAM
// slave  = packer view (consumes pixels, drives BRAM port)
// master = source/memory view
interface stereo_frame_packer_if #(
  parameter int PIX_W      = 8,
  parameter int BLOCK_SIZE = 6,
  parameter int ADDR_W     = 14
);
  logic                        pixel_valid_in;
  logic [PIX_W-1:0]            pixel_in;
  logic                        sof_in;
  logic                        bram_we_out;
  logic [ADDR_W-1:0]           bram_addr_out;
  logic [PIX_W*BLOCK_SIZE-1:0] bram_din_out;

  modport master (
    output pixel_valid_in, pixel_in, sof_in,
    input  bram_we_out, bram_addr_out, bram_din_out
  );

  modport slave (
    input  pixel_valid_in, pixel_in, sof_in,
    output bram_we_out, bram_addr_out, bram_din_out
  );
endinterface

// File: rtl/pixel_word_packer.sv
// Packs accepted pixels into BLOCK_SIZE-lane words.
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : with accept, restarts packing; the pixel becomes lane 0
//   accept, pixel : pixel to store in the current lane
//   word_complete : combinational, this accepted pixel fills the last lane
//   word_valid    : one-cycle pulse the cycle after word_complete
//   word          : last completed word, held until the next completion
module pixel_word_packer #(
  parameter int PIX_W      = 8,
  parameter int BLOCK_SIZE = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        accept,
  input  logic [PIX_W-1:0]            pixel,
  output logic                        word_complete,
  output logic                        word_valid,
  output logic [PIX_W*BLOCK_SIZE-1:0] word
);
  localparam int LANE_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BLOCK_SIZE - 1);

  logic [LANE_W-1:0]                lane;
  logic [BLOCK_SIZE-1:0][PIX_W-1:0] shift;
  logic [BLOCK_SIZE-1:0][PIX_W-1:0] filled;
  logic [BLOCK_SIZE-1:0][PIX_W-1:0] seeded;

  // filled: current partial word with this pixel dropped into its lane
  // seeded: fresh word holding only this pixel (resync / first pixel)
  always_comb begin
    filled       = shift;
    filled[lane] = pixel;
    seeded       = '0;
    seeded[0]    = pixel;
  end

  // A clearing pixel never completes a word: the partial word is abandoned.
  assign word_complete = accept && !clear && (lane == LAST_LANE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane       <= '0;
      shift      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= word_complete;
      if (accept) begin
        if (clear) begin
          shift <= seeded;
          lane  <= LANE_W'(1);
        end else begin
          shift <= filled;
          if (lane == LAST_LANE) begin
            lane <= '0;
            word <= filled;
          end else begin
            lane <= lane + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: rtl/stereo_frame_packer.sv
// Frame packer for one eye: captures one raster frame after start_in,
// packs BLOCK_SIZE pixels per word and writes the words row-major into
// the eye's image BRAM, then pulses frame_done_out.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   start_in       : arm capture of one frame (only honoured in IDLE)
//   bus (slave)    : pixel stream in, BRAM write port out
//   busy_out       : high whenever not IDLE
//   frame_done_out : one-cycle pulse after the final word write
//   error_out      : sticky, set by an unexpected sof during capture
module stereo_frame_packer #(
  parameter int PIX_W      = stereo_pkg::PIX_W,
  parameter int BLOCK_SIZE = stereo_pkg::BLOCK_SIZE,
  parameter int COLS       = stereo_pkg::IMG_COLS,
  parameter int ROWS       = stereo_pkg::IMG_ROWS,
  parameter int ADDR_W     = $clog2(ROWS * COLS / BLOCK_SIZE)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  stereo_frame_packer_if.slave bus,
  output logic                 busy_out,
  output logic                 frame_done_out,
  output logic                 error_out
);
  import stereo_pkg::*;

  localparam int WORDS = ROWS * COLS / BLOCK_SIZE;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

  packer_state_t               state, state_nxt;
  logic                        sof_hit;
  logic                        accept;
  logic                        clear;
  logic                        word_complete;
  logic                        word_valid;
  logic [PIX_W*BLOCK_SIZE-1:0] word;
  logic [ADDR_W-1:0]           word_cnt;
  logic [ADDR_W-1:0]           addr_q;
  logic                        done_q;
  logic                        error_q;

  assign sof_hit = bus.pixel_valid_in && bus.sof_in;
  // WAIT_SOF only lets the tagged pixel through; CAPTURE takes every pixel.
  assign accept  = (state == CAPTURE && bus.pixel_valid_in) ||
                   (state == WAIT_SOF && sof_hit);
  assign clear   = sof_hit && (state == WAIT_SOF || state == CAPTURE);

  pixel_word_packer #(
    .PIX_W      (PIX_W),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_packer (
    .clk           (clk_in),
    .rst           (rst_in),
    .clear         (clear),
    .accept        (accept),
    .pixel         (bus.pixel_in),
    .word_complete (word_complete),
    .word_valid    (word_valid),
    .word          (word)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start_in) state_nxt = WAIT_SOF;
      WAIT_SOF: if (sof_hit) state_nxt = CAPTURE;
      // Leaving on completion of the last word means DONE coincides with
      // its write cycle, so the done pulse follows the write by one cycle.
      CAPTURE:  if (word_complete && word_cnt == LAST_WORD) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      word_cnt <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == DONE);
      if (state == IDLE && start_in) error_q <= 1'b0;
      else if (state == CAPTURE && sof_hit) error_q <= 1'b1;
      // Rows are word aligned, so the linear word count is the address.
      if (clear) begin
        word_cnt <= '0;
      end else if (word_complete) begin
        addr_q   <= word_cnt;
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  assign bus.bram_we_out   = word_valid;
  assign bus.bram_addr_out = addr_q;
  assign bus.bram_din_out  = word;
  assign busy_out          = (state != IDLE);
  assign frame_done_out    = done_q;
  assign error_out         = error_q;
endmodule

// File: tb/tb_stereo_frame_packer.sv
module tb_stereo_frame_packer;
  localparam int PIX_W  = 8;
  localparam int BS     = 6;
  localparam int COLS   = 12;
  localparam int ROWS   = 2;
  localparam int WORDS  = ROWS * COLS / BS;
  localparam int ADDR_W = 2;

  typedef struct {
    bit         valid;
    bit         sof;
    bit         start;
    logic [7:0] pix;
    int         cyc;
  } beat_t;

  typedef struct {
    int          addr;
    logic [47:0] data;
    int          cyc;
    logic        busy;
  } wr_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic start_in = 1'b0;
  logic busy_out, frame_done_out, error_out;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  beat_t stim[$];
  wr_t   got[$];
  wr_t   exp_q[$];
  int    done_cyc[$];
  logic  busy_at_done[$];
  wr_t   mon_w;

  logic [47:0] ref_words [4];

  stereo_frame_packer_if #(.PIX_W(PIX_W), .BLOCK_SIZE(BS), .ADDR_W(ADDR_W)) bus ();

  stereo_frame_packer #(
    .PIX_W(PIX_W), .BLOCK_SIZE(BS), .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .start_in       (start_in),
    .bus            (bus),
    .busy_out       (busy_out),
    .frame_done_out (frame_done_out),
    .error_out      (error_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor: log every write and done pulse with its cycle number.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (bus.bram_we_out === 1'b1) begin
        mon_w.addr = int'(bus.bram_addr_out);
        mon_w.data = bus.bram_din_out;
        mon_w.cyc  = cyc;
        mon_w.busy = busy_out;
        got.push_back(mon_w);
      end
      if (frame_done_out === 1'b1) begin
        done_cyc.push_back(cyc);
        busy_at_done.push_back(busy_out);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_beat(input bit valid, input bit sof, input logic [7:0] pix, input bit start);
    beat_t b;
    b.valid = valid; b.sof = sof; b.pix = pix; b.start = start; b.cyc = 0;
    stim.push_back(b);
  endtask

  task automatic new_scenario();
    stim.delete(); got.delete(); done_cyc.delete(); busy_at_done.delete();
  endtask

  task automatic arm();
    @(negedge clk_in); start_in = 1'b1;
    @(negedge clk_in); start_in = 1'b0;
  endtask

  task automatic drive_stim();
    foreach (stim[i]) begin
      @(negedge clk_in);
      bus.pixel_valid_in = stim[i].valid;
      bus.sof_in         = stim[i].sof;
      bus.pixel_in       = stim[i].pix;
      start_in           = stim[i].start;
      stim[i].cyc        = cyc;
    end
    @(negedge clk_in);
    bus.pixel_valid_in = 1'b0;
    bus.sof_in         = 1'b0;
    start_in           = 1'b0;
  endtask

  // Reference model: a frame is the run of valid pixels since the latest
  // tagged pixel; every BS pixels of that run form one word, numbered from
  // 0 since the latest tag. Any tag after the first sets the error flag.
  // A word is written one cycle after its last pixel, done follows by one.
  function automatic void build_expected(output bit err, output int exp_done);
    logic [7:0]  run[$];
    bit          capturing;
    int          nwords;
    logic [47:0] w;
    wr_t         e;
    capturing = 0; nwords = 0; err = 0; exp_done = -1;
    exp_q.delete();
    foreach (stim[i]) begin
      if (nwords == WORDS) break;
      if (!stim[i].valid) continue;
      if (stim[i].sof) begin
        if (capturing) err = 1;
        capturing = 1;
        nwords = 0;
        run.delete();
        run.push_back(stim[i].pix);
      end else if (capturing) begin
        run.push_back(stim[i].pix);
      end
      if (run.size() == BS) begin
        w = '0;
        for (int k = 0; k < BS; k++) w = w | (48'(run[k]) << (8 * k));
        e.addr = nwords; e.data = w; e.cyc = stim[i].cyc + 1; e.busy = 1'b1;
        exp_q.push_back(e);
        nwords++;
        run.delete();
        if (nwords == WORDS) exp_done = stim[i].cyc + 2;
      end
    end
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_in = 1'b1; start_in = 1'b1;
    bus.pixel_valid_in = 1'b1; bus.sof_in = 1'b1; bus.pixel_in = 8'hAA;
    repeat (3) @(negedge clk_in);
    n_tests++;
    if ({busy_out, frame_done_out, error_out, bus.bram_we_out} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0000", {busy_out, frame_done_out, error_out, bus.bram_we_out});
    end
    n_tests++;
    if (bus.bram_addr_out !== 2'd0) begin
      n_fail++; $display("FAIL reset_addr: got %h required 0", bus.bram_addr_out);
    end
    n_tests++;
    if (bus.bram_din_out !== 48'd0) begin
      n_fail++; $display("FAIL reset_din: got %h required 0", bus.bram_din_out);
    end
    start_in = 1'b0; bus.pixel_valid_in = 1'b0; bus.sof_in = 1'b0;
    @(negedge clk_in); rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    n_tests++;
    if (busy_out !== 1'b0 || bus.bram_we_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: busy %b we %b required 0 0", busy_out, bus.bram_we_out);
    end
  endtask

  task automatic test_back_to_back();
    bit err; int edone;
    new_scenario();
    for (int i = 1; i <= 24; i++) push_beat(1'b1, i == 1, 8'(i), 1'b0);
    arm();
    n_tests++;
    if (busy_out !== 1'b1) begin
      n_fail++; $display("FAIL b2b_busy_armed: got %b required 1", busy_out);
    end
    drive_stim();
    repeat (4) @(negedge clk_in);
    build_expected(err, edone);
    n_tests++;
    if (got.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_write_count: got %0d required %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_tests++;
      if (got[i].addr != exp_q[i].addr || got[i].data !== exp_q[i].data || got[i].cyc != exp_q[i].cyc) begin
        n_fail++;
        $display("FAIL b2b_write%0d: got a=%0d d=%h c=%0d required a=%0d d=%h c=%0d", i,
                 got[i].addr, got[i].data, got[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
      end
      n_tests++;
      if (got[i].data !== ref_words[i]) begin
        n_fail++; $display("FAIL b2b_const%0d: got %h required %h", i, got[i].data, ref_words[i]);
      end
    end
    n_tests++;
    if (done_cyc.size() != 1 || done_cyc[0] != edone || busy_at_done[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done: got %0d pulses first@%0d required 1 pulse @%0d with busy 0",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, edone);
    end
    n_tests++;
    if (got.size() == 4 && got[3].busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_busy_last_write: got %b required 1", got[3].busy);
    end
    n_tests++;
    if (error_out !== 1'b0) begin
      n_fail++; $display("FAIL b2b_error: got %b required 0", error_out);
    end
  endtask

  task automatic test_gaps();
    bit err; int edone;
    new_scenario();
    for (int i = 1; i <= 24; i++) begin
      push_beat(1'b1, i == 1, 8'(i), 1'b0);
      push_beat(1'b0, 1'b0, 8'($urandom), 1'b0);
    end
    arm();
    drive_stim();
    repeat (4) @(negedge clk_in);
    build_expected(err, edone);
    n_tests++;
    if (got.size() != 4) begin
      n_fail++; $display("FAIL gaps_write_count: got %0d required 4", got.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_tests++;
      if (got[i].addr != i || got[i].data !== ref_words[i] || got[i].cyc != exp_q[i].cyc) begin
        n_fail++;
        $display("FAIL gaps_write%0d: got a=%0d d=%h c=%0d required a=%0d d=%h c=%0d", i,
                 got[i].addr, got[i].data, got[i].cyc, i, ref_words[i], exp_q[i].cyc);
      end
    end
    n_tests++;
    if (done_cyc.size() != 1 || done_cyc[0] != edone) begin
      n_fail++; $display("FAIL gaps_done: got %0d pulses required 1 @%0d", done_cyc.size(), edone);
    end
  endtask

  task automatic test_random();
    bit err; int edone; int cnt; int nz;
    for (int f = 0; f < 3; f++) begin
      new_scenario();
      nz = int'($urandom_range(0, 3));
      for (int j = 0; j < nz; j++) push_beat(1'($urandom_range(0, 1)), 1'b0, 8'($urandom), 1'b0);
      push_beat(1'b1, 1'b1, 8'($urandom), 1'b0);
      cnt = 1;
      while (cnt < 24) begin
        if ($urandom_range(0, 3) == 0) begin
          push_beat(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
        end else begin
          push_beat(1'b1, 1'b0, 8'($urandom), 1'b0);
          cnt++;
        end
      end
      arm();
      drive_stim();
      repeat (4) @(negedge clk_in);
      build_expected(err, edone);
      n_tests++;
      if (got.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rand%0d_write_count: got %0d required %0d", f, got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
        n_tests++;
        if (got[i].addr != exp_q[i].addr || got[i].data !== exp_q[i].data || got[i].cyc != exp_q[i].cyc) begin
          n_fail++;
          $display("FAIL rand%0d_write%0d: got a=%0d d=%h c=%0d required a=%0d d=%h c=%0d", f, i,
                   got[i].addr, got[i].data, got[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
        end
      end
      n_tests++;
      if (done_cyc.size() != 1 || done_cyc[0] != edone || error_out !== 1'(err)) begin
        n_fail++;
        $display("FAIL rand%0d_done_err: got %0d pulses err %b required 1 @%0d err %b",
                 f, done_cyc.size(), error_out, edone, err);
      end
    end
  endtask

  task automatic test_resync();
    bit err; int edone;
    new_scenario();
    for (int i = 1; i <= 8; i++) push_beat(1'b1, i == 1, 8'(i), 1'b0);
    push_beat(1'b1, 1'b1, 8'h55, 1'b0);
    for (int i = 1; i < 24; i++) push_beat(1'b1, 1'b0, 8'($urandom), 1'b0);
    arm();
    drive_stim();
    repeat (4) @(negedge clk_in);
    build_expected(err, edone);
    n_tests++;
    if (got.size() != exp_q.size()) begin
      n_fail++; $display("FAIL resync_write_count: got %0d required %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_tests++;
      if (got[i].addr != exp_q[i].addr || got[i].data !== exp_q[i].data || got[i].cyc != exp_q[i].cyc) begin
        n_fail++;
        $display("FAIL resync_write%0d: got a=%0d d=%h c=%0d required a=%0d d=%h c=%0d", i,
                 got[i].addr, got[i].data, got[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
      end
    end
    n_tests++;
    if (got.size() < 2 || got[0].data !== ref_words[0] || got[1].addr != 0 || got[1].data[7:0] !== 8'h55) begin
      n_fail++; $display("FAIL resync_restart: got %0d writes required addr0 word then addr0 with 55 in lane 0", got.size());
    end
    n_tests++;
    if (error_out !== 1'b1) begin
      n_fail++; $display("FAIL resync_error_sticky: got %b required 1", error_out);
    end
  endtask

  task automatic test_pre_sof();
    bit err; int edone;
    new_scenario();
    for (int i = 0; i < 3; i++) push_beat(1'b1, 1'b0, 8'hE0 + 8'(i), 1'b0);
    for (int i = 1; i <= 24; i++) push_beat(1'b1, i == 1, 8'(i), 1'b0);
    arm();
    n_tests++;
    if (error_out !== 1'b0) begin
      n_fail++; $display("FAIL presof_error_cleared: got %b required 0", error_out);
    end
    drive_stim();
    repeat (4) @(negedge clk_in);
    build_expected(err, edone);
    n_tests++;
    if (got.size() != 4) begin
      n_fail++; $display("FAIL presof_write_count: got %0d required 4", got.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_tests++;
      if (got[i].addr != i || got[i].data !== ref_words[i] || got[i].cyc != exp_q[i].cyc) begin
        n_fail++;
        $display("FAIL presof_write%0d: got a=%0d d=%h c=%0d required a=%0d d=%h c=%0d", i,
                 got[i].addr, got[i].data, got[i].cyc, i, ref_words[i], exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_reset_abort();
    bit err; int edone;
    new_scenario();
    for (int i = 1; i <= 10; i++) push_beat(1'b1, i == 1, 8'(i), 1'b0);
    arm();
    drive_stim();
    #2 rst_in = 1'b1;
    #1;
    n_tests++;
    if ({busy_out, frame_done_out, error_out, bus.bram_we_out} !== 4'b0000 ||
        bus.bram_addr_out !== 2'd0 || bus.bram_din_out !== 48'd0) begin
      n_fail++;
      $display("FAIL abort_async_clear: flags %b addr %h din %h required all 0",
               {busy_out, frame_done_out, error_out, bus.bram_we_out}, bus.bram_addr_out, bus.bram_din_out);
    end
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (4) @(negedge clk_in);
    n_tests++;
    if (got.size() != 1 || busy_out !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_write: got %0d writes busy %b required 1 write busy 0", got.size(), busy_out);
    end
    new_scenario();
    for (int i = 1; i <= 24; i++) push_beat(1'b1, i == 1, 8'(i), 1'b0);
    arm();
    drive_stim();
    repeat (4) @(negedge clk_in);
    build_expected(err, edone);
    n_tests++;
    if (got.size() != 4 || done_cyc.size() != 1) begin
      n_fail++; $display("FAIL abort_refill_count: got %0d writes %0d done required 4 and 1", got.size(), done_cyc.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_tests++;
      if (got[i].addr != i || got[i].data !== ref_words[i] || got[i].cyc != exp_q[i].cyc) begin
        n_fail++;
        $display("FAIL abort_refill%0d: got a=%0d d=%h required a=%0d d=%h", i,
                 got[i].addr, got[i].data, i, ref_words[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    bit err; int edone;
    new_scenario();
    for (int i = 1; i <= 24; i++) push_beat(1'b1, i == 1, 8'(i), (i == 10) || (i == 11));
    push_beat(1'b0, 1'b0, 8'h00, 1'b1);  // start held during the DONE cycle
    arm();
    drive_stim();
    repeat (5) @(negedge clk_in);
    build_expected(err, edone);
    n_tests++;
    if (got.size() != 4 || done_cyc.size() != 1 || done_cyc[0] != edone) begin
      n_fail++; $display("FAIL start_ign_frame: got %0d writes %0d done required 4 and 1 @%0d", got.size(), done_cyc.size(), edone);
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_tests++;
      if (got[i].addr != exp_q[i].addr || got[i].data !== exp_q[i].data || got[i].cyc != exp_q[i].cyc) begin
        n_fail++;
        $display("FAIL start_ign_write%0d: got a=%0d d=%h c=%0d required a=%0d d=%h c=%0d", i,
                 got[i].addr, got[i].data, got[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
      end
    end
    n_tests++;
    if (busy_out !== 1'b0 || error_out !== 1'b0) begin
      n_fail++; $display("FAIL start_ign_rearm: busy %b err %b required 0 0", busy_out, error_out);
    end
  endtask

  initial begin
    ref_words[0] = 48'h060504030201;
    ref_words[1] = 48'h0C0B0A090807;
    ref_words[2] = 48'h1211100F0E0D;
    ref_words[3] = 48'h181716151413;
    bus.pixel_valid_in = 1'b0;
    bus.sof_in         = 1'b0;
    bus.pixel_in       = 8'h00;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_random();
    test_resync();
    test_pre_sof();
    test_reset_abort();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/stereo_frame_packer.md
Name: stereo_frame_packer

Overview:
- Upstream stage of the stereo disparity engine: one instance per eye (left, right).
- Accepts a raster stream of 8-bit grayscale pixels for one frame and packs each run of BLOCK_SIZE consecutive pixels into one word.
- Writes the packed words into that eye's image BRAM: 48-bit words, row-major, ROWS*COLS/BLOCK_SIZE deep.
- Pulses frame_done_out when the frame is fully stored; the frame controller uses this pulse as its new-frame trigger.

Parameters:
- PIX_W, 8, bits per pixel.
- BLOCK_SIZE, 6, pixels per BRAM word; word width = PIX_W*BLOCK_SIZE.
- COLS, 240, pixels per stored row; must be a multiple of BLOCK_SIZE.
- ROWS, 320, stored rows per frame.
- ADDR_W, $clog2(ROWS*COLS/BLOCK_SIZE) (14), BRAM address width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- start_in  input  1  arms capture of one frame; honoured only in IDLE.
- pixel_valid_in  input  1  pixel_in is valid this cycle.
- pixel_in  input  PIX_W  grayscale pixel, row-major order.
- sof_in  input  1  start-of-frame marker; qualified by pixel_valid_in, tags the first pixel of a frame.
- busy_out  output  1  high in any state except IDLE.
- bram_we_out  output  1  BRAM write enable, one cycle per word.
- bram_addr_out  output  ADDR_W  BRAM word address.
- bram_din_out  output  PIX_W*BLOCK_SIZE  packed word.
- frame_done_out  output  1  one-cycle pulse after the final word write.
- error_out  output  1  sticky resync flag.

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - All outputs 0; internal shift register, lane counter and word counter cleared.
- States: IDLE, WAIT_SOF, CAPTURE, DONE.
- IDLE:
  - start_in -> WAIT_SOF; error_out cleared on the same edge.
  - Pixels are ignored.
- WAIT_SOF:
  - Pixels without sof_in are dropped.
  - pixel_valid_in && sof_in -> that pixel is lane 0 of word 0; go to CAPTURE.
- CAPTURE, each accepted pixel:
  - Stored in lane = lane counter, at bits [PIX_W*lane +: PIX_W] (lane 0 in the LSBs).
  - Lane counter wraps 0..BLOCK_SIZE-1.
- Word completion:
  - On the pixel filling lane BLOCK_SIZE-1, the next cycle has bram_we_out=1, bram_din_out=full word, bram_addr_out=word counter.
  - Write latency is exactly 1 cycle from acceptance of the last lane.
  - Word counter increments after the write.
  - bram_we_out is high for exactly one cycle per word.
- Between writes: bram_din_out and bram_addr_out hold their last values.
- Throughput: one pixel per cycle sustained; gaps in pixel_valid_in are allowed anywhere.
- Frame end:
  - The write of word ROWS*COLS/BLOCK_SIZE-1 moves the FSM to DONE.
  - DONE asserts frame_done_out for 1 cycle, then returns to IDLE.
  - Pixels arriving in DONE or IDLE are ignored.
- sof_in while in CAPTURE, at any point other than the expected first pixel:
  - Set error_out (sticky).
  - Discard the partial word; reset lane and word counters; the tagged pixel becomes lane 0 of word 0.
  - Stay in CAPTURE; no write is issued for the discarded partial word.
- sof_in on the same cycle as a word-completing pixel: sof wins, and the completing word is NOT written.
- start_in outside IDLE is ignored (no re-arm, error_out unaffected).
- rst_in mid-frame: immediate abort to IDLE; no pending write is issued after reset asserts.
- Address arithmetic:
  - The word counter is ADDR_W bits; frame end is detected by equality with the last index, never by overflow.
  - Rows are word-aligned, so address = row*(COLS/BLOCK_SIZE) + column/BLOCK_SIZE, which equals the linear word count.

Decomposition:
- Shared package stereo_pkg holds:
  - typedef enum for the packer FSM states;
  - constants PIX_W, BLOCK_SIZE, IMG_COLS=240, IMG_ROWS=320, WORDS_PER_ROW=COLS/BLOCK_SIZE;
  - the packed-word typedef logic [BLOCK_SIZE-1:0][PIX_W-1:0].
- Sub-module pixel_word_packer:
  - Lane counter, shift register and word_valid pulse.
  - Synchronous clear input, used for sof resync.
- Top of this block: FSM, word counter and BRAM port registers.

Test Plan (ROWS=2, COLS=12, BLOCK_SIZE=6, so 4 words):
- Reset, start_in, then 24 back-to-back pixels 0x01..0x18 with sof on 0x01 -> writes:
  - addr 0 = 0x060504030201;
  - addr 1 = 0x0C0B0A090807;
  - addr 2 = 0x1211100F0E0D;
  - addr 3 = 0x181716151413.
  - Each write lands 1 cycle after its 6th pixel; frame_done_out pulses once, 1 cycle after the addr-3 write; busy_out falls with it.
- Same frame with pixel_valid_in toggling 1/0 -> identical words and addresses; exactly 4 write pulses.
- 3 pixels before sof, then the frame -> the pre-sof pixels are dropped; words identical to the first test.
- sof re-asserted on the 9th pixel (0x55) -> error_out=1 sticky.
  - The word at addr 0 written before the resync remains; the partial second word is discarded.
  - The next write is addr 0 with 0x55 in the LSB lane.
  - The next accepted start_in clears error_out.
- rst_in asserted after 10 pixels -> all outputs 0 asynchronously; no further we.
  - A new start_in plus a full frame then produces all 4 correct words.
- start_in pulsed during CAPTURE and in DONE -> no state change; frame completes normally with a single frame_done_out pulse.
